para_smooth: RTL and testbench
==============================

PARA_SMOOTH -- requirements
Module: para_smooth

Interface
REQ-001 Parameter DW, 16, sample width of ad_data and sm_data.
REQ-002 Parameter SMW_MAX, 4, maximum window exponent; buffer depth = 2^SMW_MAX = 16.
REQ-003 clk_sys  input  1  system clock; one clock, all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ad_data  input  DW  raw unsigned ADC sample, qualified by ad_vld.
REQ-006 ad_vld  input  1  one-cycle strobe, one sample per assertion; no back-pressure.
REQ-007 cfg_smw  input  3  window exponent k; window N = 2^k; values above SMW_MAX are clamped to SMW_MAX.
REQ-008 stu_fill  output  1  high while the window is still filling after reset or a cfg_smw change.
REQ-009 sm_data  output  DW  smoothed sample = floor(sum of last N samples / N); feeds para_hit sm_data.
REQ-010 sm_vld  output  1  one-cycle strobe qualifying sm_data; feeds para_hit sm_vld.

Function
REQ-011 The block SHALL hold the last 16 accepted samples in a circular buffer with a 4-bit write pointer that wraps 15 -> 0.
REQ-012 The accumulator SHALL be DW+SMW_MAX = 20 bits wide and unsigned, updated on each ad_vld as acc = acc + ad_data - sample[wptr - N]; no overflow is possible.
REQ-013 sm_data SHALL equal acc >> k (truncation, no rounding), registered.
REQ-014 Latency: sm_vld SHALL assert exactly 1 clk_sys cycle after the ad_vld that completes the window; sm_data is stable until the next sm_vld.
REQ-015 The state machine SHALL have two states: S_FILL and S_RUN.
REQ-016 S_FILL: a fill counter counts accepted samples; sm_vld stays low; stu_fill = 1; on the N-th sample, go to S_RUN and emit the first sm_vld.
REQ-017 S_RUN: every ad_vld SHALL produce exactly one sm_vld one cycle later; stu_fill = 0.
REQ-018 The block SHALL register cfg_smw internally. Any change of the clamped value SHALL, on the next cycle, clear acc and the fill counter and enter S_FILL. A sample arriving in that same cycle is discarded.
REQ-019 k = 0 (N = 1): S_FILL lasts one sample; sm_data SHALL equal the previous ad_data with 1-cycle latency.
REQ-020 ad_vld on consecutive cycles (back-to-back) SHALL be sustained with no sample loss in every state.

Reset
REQ-021 On rst_n low, asynchronously: sm_data = 0, sm_vld = 0, stu_fill = 1, acc = 0, wptr = 0, fill counter = 0, state = S_FILL, registered cfg = 0. Buffer contents need not be cleared.
REQ-022 After reset release, operation SHALL start on the first ad_vld; a reset in mid-window discards all partial sums.

Configuration
REQ-023 Macro PARA_SMOOTH_PEAK_EN, when defined, SHALL add input cfg_pk_clr (1 bit) and output stu_peak (DW bits).
REQ-024 stu_peak SHALL hold the maximum sm_data emitted since reset or since cfg_pk_clr. It resets to 0. cfg_pk_clr has priority over a simultaneous sm_vld, and that sample is not included.
REQ-025 Without PARA_SMOOTH_PEAK_EN, neither port nor peak register SHALL exist; all other behaviour is identical.

Structure
REQ-026 The shared package para_pkg SHALL hold PARA_DW = 16, PARA_SMW_MAX = 4, PARA_ACC_W = 20 and the state encoding S_FILL/S_RUN.
REQ-027 The circular buffer SHALL be one sub-module, smooth_buf, that provides write on ad_vld and combinational read of the oldest-in-window sample at offset N. The filter, FSM and peak logic stay in para_smooth.

Verification
REQ-028 cfg_smw = 2, samples 4, 8, 12, 16 -> no sm_vld for the first 3; sm_data = 10 one cycle after the 4th; then sample 20 -> sm_data = 14.
REQ-029 cfg_smw = 4, 20 back-to-back samples of 0xFFFF -> first sm_vld after the 16th, sm_data = 0xFFFF, then 4 more strobes, no overflow.
REQ-030 cfg_smw = 0, ad_data = 0x1234 -> sm_vld and sm_data = 0x1234 exactly one cycle later.
REQ-031 In S_RUN with cfg_smw = 3, change to 1 -> stu_fill rises, 2 fresh samples 6 and 10 -> sm_data = 8; no stale sample mixed in.
REQ-032 Assert rst_n low mid-window with cfg_smw = 2 after 2 samples -> all outputs reset immediately; 4 new samples are needed before sm_vld.
REQ-033 With PARA_SMOOTH_PEAK_EN, sm_data sequence 5, 9, 3 -> stu_peak = 9. Then cfg_pk_clr together with sm_data = 7 -> stu_peak = 0; the next sample 2 -> stu_peak = 2.

Source files
------------

// File: rtl/para_pkg.sv
// Shared constants and state encoding for the parameter smoothing path.
package para_pkg;

   localparam int PARA_DW      = 16;
   localparam int PARA_SMW_MAX = 4;
   localparam int PARA_ACC_W   = PARA_DW + PARA_SMW_MAX;

   typedef enum logic {
      S_FILL = 1'b0,
      S_RUN  = 1'b1
   } smooth_state_t;

   function automatic logic [2:0] clamp_smw(
      input logic [2:0] smw,
      input int         smw_max
   );
      return (smw > 3'(smw_max)) ? 3'(smw_max) : smw;
   endfunction

endpackage

// File: rtl/smooth_buf.sv
// Circular sample buffer: write on strobe, combinational read of the
// sample rd_off positions behind the write pointer.
module smooth_buf
   import para_pkg::*;
#(
   parameter int DW = PARA_DW,
   parameter int AW = PARA_SMW_MAX
) (
   input  logic          clk_sys,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] rd_off,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [2**AW];
   logic [AW-1:0] wptr;

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
      end else if (wr_en) begin
         wptr <= wptr + 1'b1;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (wr_en) begin
         mem[wptr] <= wr_data;
      end
   end

   // Offset 0 means a full-depth window: the slot about to be overwritten.
   assign rd_data = mem[wptr - rd_off];

endmodule

// File: rtl/para_smooth.sv
// Moving-average smoother over 2^k samples with fill tracking.
// Optional peak hold enabled by macro PARA_SMOOTH_PEAK_EN.
module para_smooth
   import para_pkg::*;
#(
   parameter int DW      = PARA_DW,
   parameter int SMW_MAX = PARA_SMW_MAX
) (
   input  logic          clk_sys,
   input  logic          rst_n,
   input  logic [DW-1:0] ad_data,
   input  logic          ad_vld,
   input  logic [2:0]    cfg_smw,
`ifdef PARA_SMOOTH_PEAK_EN
   input  logic          cfg_pk_clr,
   output logic [DW-1:0] stu_peak,
`endif
   output logic          stu_fill,
   output logic [DW-1:0] sm_data,
   output logic          sm_vld
);

   localparam int ACC_W = DW + SMW_MAX;
   localparam int CW    = SMW_MAX + 1;

   smooth_state_t    state;
   logic [2:0]       k_r;
   logic [2:0]       k_in;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_nxt;
   logic [CW-1:0]    fill_cnt;
   logic [CW-1:0]    fill_nxt;
   logic [CW-1:0]    win_n;
   logic [DW-1:0]    old;
   logic             cfg_chg;
   logic             accept;

   assign k_in     = clamp_smw(cfg_smw, SMW_MAX);
   assign cfg_chg  = (k_in != k_r);
   assign accept   = ad_vld && !cfg_chg;
   assign win_n    = CW'(1) << k_r;
   assign fill_nxt = fill_cnt + 1'b1;

   // Nothing leaves the window until it has been filled with fresh samples.
   assign acc_nxt = acc + ACC_W'(ad_data)
                  - ((state == S_RUN) ? ACC_W'(old) : '0);

   smooth_buf #(
      .DW (DW),
      .AW (SMW_MAX)
   ) u_buf (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .wr_en   (accept),
      .wr_data (ad_data),
      .rd_off  (win_n[SMW_MAX-1:0]),
      .rd_data (old)
   );

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_FILL;
         k_r      <= '0;
         acc      <= '0;
         fill_cnt <= '0;
         sm_data  <= '0;
         sm_vld   <= 1'b0;
         stu_fill <= 1'b1;
      end else begin
         sm_vld <= 1'b0;
         if (cfg_chg) begin
            k_r      <= k_in;
            acc      <= '0;
            fill_cnt <= '0;
            state    <= S_FILL;
            stu_fill <= 1'b1;
         end else if (ad_vld) begin
            acc <= acc_nxt;
            unique case (state)
               S_FILL: begin
                  fill_cnt <= fill_nxt;
                  if (fill_nxt == win_n) begin
                     state    <= S_RUN;
                     stu_fill <= 1'b0;
                     sm_vld   <= 1'b1;
                     sm_data  <= DW'(acc_nxt >> k_r);
                  end
               end
               S_RUN: begin
                  sm_vld  <= 1'b1;
                  sm_data <= DW'(acc_nxt >> k_r);
               end
            endcase
         end
      end
   end

`ifdef PARA_SMOOTH_PEAK_EN
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         stu_peak <= '0;
      end else if (cfg_pk_clr) begin
         stu_peak <= '0;
      end else if (sm_vld && (sm_data > stu_peak)) begin
         stu_peak <= sm_data;
      end
   end
`endif

endmodule

// File: tb/tb_para_smooth.sv
// Randomized and directed bench for para_smooth against a queue-based
// moving-average model.
module tb_para_smooth;

   logic        clk_sys;
   logic        rst_n;
   logic [15:0] ad_data;
   logic        ad_vld;
   logic [2:0]  cfg_smw;
   logic        stu_fill;
   logic [15:0] sm_data;
   logic        sm_vld;
`ifdef PARA_SMOOTH_PEAK_EN
   logic        cfg_pk_clr;
   logic [15:0] stu_peak;
`endif

   para_smooth dut (
      .clk_sys    (clk_sys),
      .rst_n      (rst_n),
      .ad_data    (ad_data),
      .ad_vld     (ad_vld),
      .cfg_smw    (cfg_smw),
`ifdef PARA_SMOOTH_PEAK_EN
      .cfg_pk_clr (cfg_pk_clr),
      .stu_peak   (stu_peak),
`endif
      .stu_fill   (stu_fill),
      .sm_data    (sm_data),
      .sm_vld     (sm_vld)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   int n_cmp = 0;
   int n_err = 0;

   int          m_k;
   int          m_cnt;
   logic [15:0] win[$];
   logic        exp_vld;
   logic [15:0] exp_data;
   logic [15:0] m_peak;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic int clamp(input logic [2:0] c);
      return (c > 3'd4) ? 4 : int'(c);
   endfunction

   task automatic model_reset();
      m_k      = 0;
      m_cnt    = 0;
      win.delete();
      exp_vld  = 1'b0;
      exp_data = '0;
      m_peak   = '0;
   endtask

   task automatic model_update(input logic v, input logic [15:0] d,
                               input logic [2:0] c, input logic pk);
      longint s;
      int     n;
      if (pk) m_peak = '0;
      else if (exp_vld && exp_data > m_peak) m_peak = exp_data;
      exp_vld = 1'b0;
      if (clamp(c) != m_k) begin
         m_k   = clamp(c);
         m_cnt = 0;
         win.delete();
      end else if (v) begin
         win.push_back(d);
         if (win.size() > 16) void'(win.pop_front());
         if (m_cnt < 100) m_cnt++;
         n = 1 << m_k;
         if (m_cnt >= n) begin
            s = 0;
            for (int i = 0; i < n; i++) s += win[win.size() - 1 - i];
            exp_vld  = 1'b1;
            exp_data = 16'(s / n);
         end
      end
   endtask

   task automatic check_out();
      chk("sm_vld", sm_vld, exp_vld);
      chk("sm_data", sm_data, exp_data);
      chk("stu_fill", stu_fill, m_cnt < (1 << m_k));
`ifdef PARA_SMOOTH_PEAK_EN
      chk("stu_peak", stu_peak, m_peak);
`endif
   endtask

   task automatic step(input logic v, input logic [15:0] d,
                       input logic [2:0] c, input logic pk = 1'b0);
      ad_vld  = v;
      ad_data = d;
      cfg_smw = c;
`ifdef PARA_SMOOTH_PEAK_EN
      cfg_pk_clr = pk;
`endif
      @(posedge clk_sys);
      model_update(v, d, c, pk);
      #1;
      check_out();
   endtask

   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_vld", sm_vld, 1'b0);
      chk("rst_data", sm_data, 16'h0);
      chk("rst_fill", stu_fill, 1'b1);
      @(posedge clk_sys);
      @(posedge clk_sys);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "time limit");
   end

   initial begin
      logic [2:0] c;
      rst_n   = 1'b1;
      ad_vld  = 1'b0;
      ad_data = '0;
      cfg_smw = 3'd2;
`ifdef PARA_SMOOTH_PEAK_EN
      cfg_pk_clr = 1'b0;
`endif
      model_reset();
      do_reset();

      // window of 4
      step(0, 0, 2);
      step(0, 0, 2);
      step(1, 4, 2);
      step(1, 8, 2);
      step(1, 12, 2);
      step(1, 16, 2);
      chk("w4_first", sm_data, 16'd10);
      chk("w4_vld", sm_vld, 1'b1);
      step(1, 20, 2);
      chk("w4_next", sm_data, 16'd14);

      // full window of all-ones, back-to-back
      step(0, 0, 4);
      for (int i = 0; i < 20; i++) begin
         step(1, 16'hFFFF, 4);
         if (i == 14) chk("w16_pre", sm_vld, 1'b0);
         if (i >= 15) chk("w16_ones", sm_data, 16'hFFFF);
      end

      // window of 1
      step(0, 0, 0);
      step(1, 16'h1234, 0);
      chk("w1_data", sm_data, 16'h1234);
      chk("w1_vld", sm_vld, 1'b1);

      // window change while running, sample in change cycle dropped
      step(0, 0, 3);
      for (int i = 0; i < 10; i++) step(1, 16'(100 + i * 7), 3);
      step(1, 16'hBEEF, 1);
      chk("chg_fill", stu_fill, 1'b1);
      step(1, 6, 1);
      step(1, 10, 1);
      chk("chg_data", sm_data, 16'd8);

      // reset mid-window
      step(0, 0, 2);
      step(1, 40, 2);
      step(1, 44, 2);
      do_reset();
      step(0, 0, 2);
      for (int i = 0; i < 4; i++) step(1, 16'(i + 1), 2);
      chk("rst_refill", sm_data, 16'd2);

`ifdef PARA_SMOOTH_PEAK_EN
      step(0, 0, 0);
      step(1, 5, 0);
      step(1, 9, 0);
      step(1, 3, 0);
      step(1, 7, 0);
      chk("pk_hold", stu_peak, 16'd9);
      step(1, 2, 0, 1'b1);
      chk("pk_clr", stu_peak, 16'd0);
      step(0, 0, 0);
      chk("pk_after", stu_peak, 16'd2);
`endif

      // randomized traffic with occasional window changes and a reset
      c = 3'($urandom_range(0, 7));
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) == 0) c = 3'($urandom_range(0, 7));
         if (i == 1500) do_reset();
         step(($urandom_range(0, 9) < 7), 16'($urandom),
              c, ($urandom_range(0, 49) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
